ps2_scan_ctrl: RTL and testbench
================================

PS2_SCAN_CTRL -- requirements
Module: ps2_scan_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all logic on posedge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: ready  input  1  PS/2 receiver FIFO non-empty.
REQ-004 SHALL have port: data  input  8  PS/2 receiver FIFO head byte.
REQ-005 SHALL have port: overflow  input  1  PS/2 receiver FIFO overflow flag.
REQ-006 SHALL have port: nextdata_n  output  1  FIFO pop strobe, active-low, one cycle.
REQ-007 SHALL have port: evt_valid  output  1  key event held in output register.
REQ-008 SHALL have port: evt_ready  input  1  consumer accepts the event.
REQ-009 SHALL have port: evt_code  output  8  scan code of the event.
REQ-010 SHALL have port: evt_release  output  1  1 = release event, 0 = press event.
REQ-011 SHALL have port: evt_ext  output  1  event carried an E0 prefix.
REQ-012 SHALL have port: press_cnt  output  8  count of distinct presses, wraps.
REQ-013 SHALL have port: key_held  output  1  a key is currently held.
REQ-014 SHALL have port: clear_seg  output  1  display blank request.
REQ-015 SHALL have port: ovf_cnt  output  4  FIFO overflow rising edges seen, saturating.

Function
REQ-016 SHALL implement FSM S_IDLE and S_POP.
REQ-017 In S_IDLE with ready=1 and (evt_valid=0 or evt_ready=1), SHALL capture data into byte_q, set nextdata_n<=0 and go to S_POP; otherwise SHALL stay in S_IDLE.
REQ-018 In S_POP SHALL set nextdata_n<=1, decode byte_q and return to S_IDLE; ready SHALL NOT be sampled in S_POP.
REQ-019 Decoding of F0 SHALL set brk flag; no event.
REQ-020 Decoding of E0 SHALL set ext flag; no event.
REQ-021 Decoding of any other byte with brk=1 SHALL emit a release event (code, ext), clear brk and ext, set clear_seg=1, and clear key_held.
REQ-022 Decoding of any other byte with brk=0 and (key_held=0 or byte differs from last_code) SHALL emit a press event, increment press_cnt mod 256, load last_code, set key_held=1, set clear_seg=0, and clear ext.
REQ-023 Decoding of any other byte with brk=0, key_held=1 and byte equal to last_code SHALL be treated as typematic repeat: no event, no count change, ext cleared.
REQ-024 An emitted event SHALL appear on evt_valid/evt_code/evt_release/evt_ext in the cycle after S_POP; latency from ready to evt_valid is 2 cycles.
REQ-025 evt_valid SHALL clear on a cycle with evt_valid=1 and evt_ready=1 unless a new event loads in that same cycle, in which case the new event wins.
REQ-026 SHALL leave evt_* fields stable while evt_valid=1 and evt_ready=0; the FIFO SHALL NOT be popped in that condition.
REQ-027 A rising edge on overflow SHALL increment ovf_cnt (saturate at 15) and clear brk and ext to resynchronise.

Reset
REQ-028 On rst=1 at posedge, SHALL set the following, with rst taking priority over every other event including an in-flight S_POP: state=S_IDLE, nextdata_n=1, evt_valid=0, evt_code=0, evt_release=0, evt_ext=0, press_cnt=0, key_held=0, last_code=0, brk=0, ext=0, clear_seg=1, ovf_cnt=0.

Configuration
REQ-029 With macro PS2_SCAN_EXT_EN defined, SHALL handle E0 as in REQ-020 and drive evt_ext from the ext flag.
REQ-030 Without PS2_SCAN_EXT_EN, SHALL decode E0 as an ordinary scan code, tie evt_ext to 0, and omit the ext flag.

Verification
REQ-031 Feed 1C, F0, 1C with evt_ready=1 -> press event 1C, then release event 1C; press_cnt=1; clear_seg goes 1 -> 0 -> 1.
REQ-032 Feed 1C, 1C, 1C, F0, 1C -> exactly one press and one release; press_cnt=1.
REQ-033 Feed 1C, then 32 with no break between them -> two press events; press_cnt=2; last_code=32.
REQ-034 With PS2_SCAN_EXT_EN defined, feed E0, 75, E0, F0, 75 -> press 75 with evt_ext=1, then release 75 with evt_ext=1; without the macro -> press E0, press 75, and so on.
REQ-035 Hold evt_ready=0 with 3 bytes queued -> exactly one nextdata_n pulse and evt fields stable; release evt_ready -> remaining bytes popped one pulse at a time.
REQ-036 Feed 256 distinct presses -> press_cnt wraps to 0; assert rst during S_POP -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/ps2_scan_ctrl.sv
// PS/2 scan-code decoder: pops bytes from a receiver FIFO and turns them into press/release events.
// Define PS2_SCAN_EXT_EN to track E0-prefixed codes on evt_ext; by default E0 is decoded as a plain code.
module ps2_scan_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic [7:0] data,
  input  logic       overflow,
  output logic       nextdata_n,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_release,
  output logic       evt_ext,
  output logic [7:0] press_cnt,
  output logic       key_held,
  output logic       clear_seg,
  output logic [3:0] ovf_cnt
);

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
`ifdef PS2_SCAN_EXT_EN
  localparam logic EXT_EN = 1'b1;
`else
  localparam logic EXT_EN = 1'b0;
`endif

  typedef enum logic {S_IDLE = 1'b0, S_POP = 1'b1} state_t;

  state_t     state_reg, state_next;
  logic       nextdata_n_reg, nextdata_n_next;
  logic [7:0] byte_reg, byte_next;
  logic       evt_valid_reg, evt_valid_next;
  logic [7:0] evt_code_reg, evt_code_next;
  logic       evt_release_reg, evt_release_next;
  logic [7:0] press_cnt_reg, press_cnt_next;
  logic       key_held_reg, key_held_next;
  logic [7:0] last_code_reg, last_code_next;
  logic       brk_reg, brk_next;
  logic       clear_seg_reg, clear_seg_next;
  logic [3:0] ovf_cnt_reg, ovf_cnt_next;
  logic       ovf_d_reg;
  logic       ovf_rise;
  logic       load_evt;

  assign ovf_rise = overflow & ~ovf_d_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      nextdata_n_reg  <= 1'b1;
      byte_reg        <= 8'h00;
      evt_valid_reg   <= 1'b0;
      evt_code_reg    <= 8'h00;
      evt_release_reg <= 1'b0;
      press_cnt_reg   <= 8'h00;
      key_held_reg    <= 1'b0;
      last_code_reg   <= 8'h00;
      brk_reg         <= 1'b0;
      clear_seg_reg   <= 1'b1;
      ovf_cnt_reg     <= 4'h0;
      ovf_d_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      nextdata_n_reg  <= nextdata_n_next;
      byte_reg        <= byte_next;
      evt_valid_reg   <= evt_valid_next;
      evt_code_reg    <= evt_code_next;
      evt_release_reg <= evt_release_next;
      press_cnt_reg   <= press_cnt_next;
      key_held_reg    <= key_held_next;
      last_code_reg   <= last_code_next;
      brk_reg         <= brk_next;
      clear_seg_reg   <= clear_seg_next;
      ovf_cnt_reg     <= ovf_cnt_next;
      ovf_d_reg       <= overflow;
    end
  end

  always_comb begin
    state_next       = state_reg;
    nextdata_n_next  = 1'b1;
    byte_next        = byte_reg;
    evt_valid_next   = evt_valid_reg;
    evt_code_next    = evt_code_reg;
    evt_release_next = evt_release_reg;
    press_cnt_next   = press_cnt_reg;
    key_held_next    = key_held_reg;
    last_code_next   = last_code_reg;
    brk_next         = brk_reg;
    clear_seg_next   = clear_seg_reg;
    ovf_cnt_next     = ovf_cnt_reg;
    load_evt         = 1'b0;

    // A consumed event drops here; a fresh event loaded below overrides this.
    if (evt_valid_reg && evt_ready) begin
      evt_valid_next = 1'b0;
    end

    unique case (state_reg)
      S_IDLE: begin
        if (ready && (!evt_valid_reg || evt_ready)) begin
          byte_next       = data;
          nextdata_n_next = 1'b0;
          state_next      = S_POP;
        end
      end
      S_POP: begin
        state_next = S_IDLE;
        if (byte_reg == BREAK_CODE) begin
          brk_next = 1'b1;
        end else if (!(EXT_EN && byte_reg == EXT_CODE)) begin
          if (brk_reg) begin
            load_evt         = 1'b1;
            evt_valid_next   = 1'b1;
            evt_code_next    = byte_reg;
            evt_release_next = 1'b1;
            brk_next         = 1'b0;
            clear_seg_next   = 1'b1;
            key_held_next    = 1'b0;
          end else if (!key_held_reg || byte_reg != last_code_reg) begin
            load_evt         = 1'b1;
            evt_valid_next   = 1'b1;
            evt_code_next    = byte_reg;
            evt_release_next = 1'b0;
            press_cnt_next   = press_cnt_reg + 8'd1;
            last_code_next   = byte_reg;
            key_held_next    = 1'b1;
            clear_seg_next   = 1'b0;
          end
        end
      end
    endcase

    // FIFO overflow may have dropped a prefix byte, so forget any pending break.
    if (ovf_rise) begin
      brk_next = 1'b0;
      if (ovf_cnt_reg != 4'hF) begin
        ovf_cnt_next = ovf_cnt_reg + 4'd1;
      end
    end
  end

`ifdef PS2_SCAN_EXT_EN
  logic ext_reg, ext_next;
  logic evt_ext_reg, evt_ext_next;

  // E0 arms the flag, F0 keeps it for the following code, any other byte consumes it.
  always_comb begin
    ext_next     = ext_reg;
    evt_ext_next = evt_ext_reg;
    if (state_reg == S_POP) begin
      if (byte_reg == EXT_CODE) begin
        ext_next = 1'b1;
      end else if (byte_reg != BREAK_CODE) begin
        ext_next = 1'b0;
      end
    end
    if (load_evt) begin
      evt_ext_next = ext_reg;
    end
    if (ovf_rise) begin
      ext_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_reg     <= 1'b0;
      evt_ext_reg <= 1'b0;
    end else begin
      ext_reg     <= ext_next;
      evt_ext_reg <= evt_ext_next;
    end
  end

  assign evt_ext = evt_ext_reg;
`else
  assign evt_ext = 1'b0;
`endif

  assign nextdata_n  = nextdata_n_reg;
  assign evt_valid   = evt_valid_reg;
  assign evt_code    = evt_code_reg;
  assign evt_release = evt_release_reg;
  assign press_cnt   = press_cnt_reg;
  assign key_held    = key_held_reg;
  assign clear_seg   = clear_seg_reg;
  assign ovf_cnt     = ovf_cnt_reg;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Scoreboard bench for ps2_scan_ctrl: a FIFO model feeds bytes, expected events are queued
// at stimulus time and a negedge monitor pops and compares every accepted event.
module tb_ps2_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ready;
  logic [7:0] data;
  logic       overflow = 1'b0;
  logic       evt_ready = 1'b1;
  logic       nextdata_n;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_release;
  logic       evt_ext;
  logic [7:0] press_cnt;
  logic       key_held;
  logic       clear_seg;
  logic [3:0] ovf_cnt;

  typedef struct packed {
    logic [7:0] code;
    logic       rel;
    logic       ext;
  } evt_t;

  evt_t       exp_q[$];
  logic [7:0] fifo_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         pops = 0;
  int         n_evt = 0;

  always #5 clk = ~clk;

  ps2_scan_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .ready       (ready),
    .data        (data),
    .overflow    (overflow),
    .nextdata_n  (nextdata_n),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_code    (evt_code),
    .evt_release (evt_release),
    .evt_ext     (evt_ext),
    .press_cnt   (press_cnt),
    .key_held    (key_held),
    .clear_seg   (clear_seg),
    .ovf_cnt     (ovf_cnt)
  );

  // Receiver FIFO model: every low cycle of the strobe removes the head byte.
  initial begin : fifo_model
    ready = 1'b0;
    data  = 8'h00;
    forever begin
      @(negedge clk);
      if (nextdata_n === 1'b0) begin
        pops++;
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      end
      ready = (fifo_q.size() != 0);
      data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end
  end

  initial begin : monitor
    evt_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
        n_cmp++;
        n_evt++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL evt_unexpected: got code=%02h rel=%0d ext=%0d, required no event",
                   evt_code, evt_release, evt_ext);
        end else begin
          e = exp_q.pop_front();
          if ({evt_code, evt_release, evt_ext} !== {e.code, e.rel, e.ext}) begin
            n_bad++;
            $display("FAIL evt_%0d: got code=%02h rel=%0d ext=%0d, required code=%02h rel=%0d ext=%0d",
                     n_evt, evt_code, evt_release, evt_ext, e.code, e.rel, e.ext);
          end else begin
            $display("evt %0d: code=%02h rel=%0d ext=%0d ok", n_evt, evt_code, evt_release, evt_ext);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic feed(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic expect_evt(input logic [7:0] c, input logic r, input logic x);
    exp_q.push_back({c, r, x});
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic drain;
    int budget = 0;
    while (fifo_q.size() != 0 && budget < 3000) begin
      step(1);
      budget++;
    end
    if (fifo_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d bytes left, required 0", fifo_q.size());
    end
    step(4);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_nextdata_n"},  nextdata_n,  1);
    check({tag, "_evt_valid"},   evt_valid,   0);
    check({tag, "_evt_code"},    evt_code,    0);
    check({tag, "_evt_release"}, evt_release, 0);
    check({tag, "_evt_ext"},     evt_ext,     0);
    check({tag, "_press_cnt"},   press_cnt,   0);
    check({tag, "_key_held"},    key_held,    0);
    check({tag, "_clear_seg"},   clear_seg,   1);
    check({tag, "_ovf_cnt"},     ovf_cnt,     0);
  endtask

  initial begin : stimulus
    int p0;
    int waited;
    step(1);
    do_reset();
    check_reset_state("rst");

    // Press then release of 1C, with pop strobe and event latency probed.
    feed(8'h1C); expect_evt(8'h1C, 1'b0, 1'b0);
    step(1);
    check("lat_pop_strobe", nextdata_n, 0);
    check("lat_no_evt_yet", evt_valid, 0);
    step(1);
    check("lat_evt_valid", evt_valid, 1);
    check("lat_strobe_1cyc", nextdata_n, 1);
    drain();
    check("t1_clear_seg_press", clear_seg, 0);
    check("t1_key_held_press", key_held, 1);
    feed(8'hF0); feed(8'h1C); expect_evt(8'h1C, 1'b1, 1'b0);
    drain();
    check("t1_press_cnt", press_cnt, 1);
    check("t1_clear_seg_rel", clear_seg, 1);
    check("t1_key_held_rel", key_held, 0);

    // Typematic repeats collapse into a single press.
    do_reset();
    feed(8'h1C); feed(8'h1C); feed(8'h1C); feed(8'hF0); feed(8'h1C);
    expect_evt(8'h1C, 1'b0, 1'b0); expect_evt(8'h1C, 1'b1, 1'b0);
    drain();
    check("t2_press_cnt", press_cnt, 1);

    // Rollover without break, then 32 repeat (ignored) and 1C (new press).
    do_reset();
    feed(8'h1C); feed(8'h32);
    expect_evt(8'h1C, 1'b0, 1'b0); expect_evt(8'h32, 1'b0, 1'b0);
    drain();
    check("t3_press_cnt", press_cnt, 2);
    feed(8'h32); feed(8'h1C); expect_evt(8'h1C, 1'b0, 1'b0);
    drain();
    check("t3_last_code", press_cnt, 3);

    // Extended key sequence.
    do_reset();
    feed(8'hE0); feed(8'h75); feed(8'hE0); feed(8'hF0); feed(8'h75);
`ifdef PS2_SCAN_EXT_EN
    expect_evt(8'h75, 1'b0, 1'b1); expect_evt(8'h75, 1'b1, 1'b1);
    drain();
    check("t4_press_cnt", press_cnt, 1);
`else
    expect_evt(8'hE0, 1'b0, 1'b0); expect_evt(8'h75, 1'b0, 1'b0);
    expect_evt(8'hE0, 1'b0, 1'b0); expect_evt(8'h75, 1'b1, 1'b0);
    drain();
    check("t4_press_cnt", press_cnt, 3);
`endif

    // Back-pressure: only one byte leaves the FIFO while the event is unconsumed.
    do_reset();
    evt_ready = 1'b0;
    p0 = pops;
    feed(8'h1C); feed(8'h32); feed(8'h4D);
    expect_evt(8'h1C, 1'b0, 1'b0); expect_evt(8'h32, 1'b0, 1'b0); expect_evt(8'h4D, 1'b0, 1'b0);
    step(8);
    check("bp_valid", evt_valid, 1);
    check("bp_code_early", evt_code, 8'h1C);
    check("bp_pops_early", pops - p0, 1);
    step(8);
    check("bp_code_late", evt_code, 8'h1C);
    check("bp_release_late", evt_release, 0);
    check("bp_pops_late", pops - p0, 1);
    check("bp_fifo_left", fifo_q.size(), 2);
    evt_ready = 1'b1;
    drain();
    check("bp_pops_total", pops - p0, 3);

    // Overflow edge clears a pending break and counts once per rising edge.
    do_reset();
    feed(8'hF0);
    drain();
    overflow = 1'b1;
    step(3);
    overflow = 1'b0;
    step(1);
    check("ovf_one_edge", ovf_cnt, 1);
    feed(8'h1C); expect_evt(8'h1C, 1'b0, 1'b0);
    drain();
    check("ovf_brk_cleared", key_held, 1);
    for (int i = 0; i < 15; i++) begin
      overflow = 1'b1;
      step(1);
      overflow = 1'b0;
      step(1);
    end
    check("ovf_saturate", ovf_cnt, 15);

    // press_cnt wraps: 1 press so far, 254 more then one final.
    for (int i = 0; i < 254; i++) begin
      feed((i % 2 == 0) ? 8'h01 : 8'h02);
      expect_evt((i % 2 == 0) ? 8'h01 : 8'h02, 1'b0, 1'b0);
    end
    drain();
    check("wrap_255", press_cnt, 255);
    feed(8'h01); expect_evt(8'h01, 1'b0, 1'b0);
    drain();
    check("wrap_0", press_cnt, 0);

    // Reset lands on the S_POP cycle of a pending press; the event must vanish.
    feed(8'h02);
    waited = 0;
    while (nextdata_n !== 1'b0 && waited < 20) begin
      step(1);
      waited++;
    end
    check("midpop_reached", nextdata_n, 0);
    rst = 1'b1;
    step(1);
    check_reset_state("midpop");
    rst = 1'b0;
    step(4);
    check("midpop_no_evt", evt_valid, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
